// File: rtl/uart_mmio.sv
// Memory-mapped UART: TX FIFO feeding a byte serializer, single-byte RX holding
// register, status/control register and a programmable baud divisor.
module uart_mmio #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [15:0] DIV_RESET   = 16'(CLKS_PER_BIT);
    localparam logic [15:0] DIV_MIN     = 16'd4;
    localparam logic [1:0]  REG_TXDATA  = 2'd0;
    localparam logic [1:0]  REG_RXDATA  = 2'd1;
    localparam logic [1:0]  REG_STATUS  = 2'd2;
    localparam logic [1:0]  REG_DIVISOR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

    logic wr_txdata_s, rd_rxdata_s, wr_status_s, wr_divisor_s;
    logic [15:0] divisor_r;
    logic        tx_ie_r;
    logic        rx_overrun_r, tx_overflow_r, rx_frame_err_r;
    logic        unused_bits_s;

    logic [7:0]  fifo_mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r;
    logic        fifo_empty_s, fifo_full_s, push_ok_s, push_drop_s;
    logic [7:0]  fifo_head_s;

    uart_state_t tx_state_r, tx_state_n;
    logic [15:0] tx_cnt_r, tx_cnt_n, tx_div_r, tx_div_n;
    logic [2:0]  tx_bit_r, tx_bit_n;
    logic [7:0]  tx_shift_r, tx_shift_n;
    logic        tx_line_r, tx_line_n, tx_pop_s, tx_cnt_end_s;
    logic        tx_busy_s, tx_empty_s;

    uart_state_t rx_state_r, rx_state_n;
    logic [15:0] rx_cnt_r, rx_cnt_n, rx_div_r, rx_div_n;
    logic [2:0]  rx_bit_r, rx_bit_n;
    logic [7:0]  rx_shift_r, rx_shift_n, rx_byte_r;
    logic        rx_meta_r, rx_sync_r, rx_prev_r, rx_valid_r;
    logic        rx_fall_s, rx_half_end_s, rx_bit_end_s, rx_done_ok_s, rx_done_err_s;

    assign wr_txdata_s   = sel & wr_en & (addr[3:2] == REG_TXDATA);
    assign rd_rxdata_s   = sel & rd_en & (addr[3:2] == REG_RXDATA);
    assign wr_status_s   = sel & wr_en & (addr[3:2] == REG_STATUS);
    assign wr_divisor_s  = sel & wr_en & (addr[3:2] == REG_DIVISOR);
    assign unused_bits_s = ^{addr[1:0], wdata[31:16]};

    // A pop in the same cycle frees the slot a push to a full FIFO lands in.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_ok_s    = wr_txdata_s & (~fifo_full_s | tx_pop_s);
    assign push_drop_s  = wr_txdata_s & fifo_full_s & ~tx_pop_s;
    assign fifo_head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];

    // FIFO storage, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= wdata[7:0];
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (tx_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Control registers and sticky flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor_r      <= DIV_RESET;
            tx_ie_r        <= 1'b0;
            rx_overrun_r   <= 1'b0;
            tx_overflow_r  <= 1'b0;
            rx_frame_err_r <= 1'b0;
        end else begin
            if (wr_divisor_s) divisor_r <= clamp_divisor(wdata[15:0]);
            if (wr_status_s)  tx_ie_r   <= wdata[8];
            rx_overrun_r   <= (rx_done_ok_s & rx_valid_r & ~rd_rxdata_s) |
                              (rx_overrun_r & ~(wr_status_s & wdata[4]));
            tx_overflow_r  <= push_drop_s | (tx_overflow_r & ~(wr_status_s & wdata[5]));
            rx_frame_err_r <= rx_done_err_s | (rx_frame_err_r & ~(wr_status_s & wdata[6]));
        end
    end

    assign tx_cnt_end_s = (tx_cnt_r == tx_div_r - 16'd1);
    assign tx_busy_s    = (tx_state_r != ST_IDLE);
    assign tx_empty_s   = fifo_empty_s & ~tx_busy_s;

    // TX next-state: STOP chains straight into START when more data is queued.
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r + 16'd1;
        tx_bit_n   = tx_bit_r;
        tx_shift_n = tx_shift_r;
        tx_div_n   = tx_div_r;
        tx_line_n  = tx_line_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_cnt_n  = 16'd0;
                tx_line_n = 1'b1;
                if (!fifo_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_n = fifo_head_s;
                    tx_div_n   = divisor_r;
                    tx_line_n  = 1'b0;
                    tx_state_n = ST_START;
                end else begin
                    tx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_end_s) begin
                    tx_cnt_n   = 16'd0;
                    tx_bit_n   = 3'd0;
                    tx_line_n  = tx_shift_r[0];
                    tx_state_n = ST_DATA;
                end else begin
                    tx_state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (tx_cnt_end_s) begin
                    tx_cnt_n = 16'd0;
                    if (tx_bit_r == 3'd7) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = ST_STOP;
                    end else begin
                        tx_bit_n   = tx_bit_r + 3'd1;
                        tx_shift_n = {1'b0, tx_shift_r[7:1]};
                        tx_line_n  = tx_shift_r[1];
                        tx_state_n = ST_DATA;
                    end
                end else begin
                    tx_state_n = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tx_cnt_end_s) begin
                    tx_cnt_n = 16'd0;
                    if (!fifo_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_n = fifo_head_s;
                        tx_div_n   = divisor_r;
                        tx_line_n  = 1'b0;
                        tx_state_n = ST_START;
                    end else begin
                        tx_line_n  = 1'b1;
                        tx_state_n = ST_IDLE;
                    end
                end else begin
                    tx_state_n = ST_STOP;
                end
            end
            default: begin
                tx_line_n  = 1'b1;
                tx_state_n = ST_IDLE;
            end
        endcase
    end

    // TX state register; the line register makes uart_tx glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_div_r   <= DIV_RESET;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bit_r   <= tx_bit_n;
            tx_shift_r <= tx_shift_n;
            tx_div_r   <= tx_div_n;
            tx_line_r  <= tx_line_n;
        end
    end

    assign rx_fall_s     = rx_prev_r & ~rx_sync_r;
    assign rx_half_end_s = (rx_cnt_r == {1'b0, rx_div_r[15:1]} - 16'd1);
    assign rx_bit_end_s  = (rx_cnt_r == rx_div_r - 16'd1);

    // RX next-state: START re-checks the line at half a bit to reject glitches.
    always_comb begin
        rx_state_n    = rx_state_r;
        rx_cnt_n      = rx_cnt_r + 16'd1;
        rx_bit_n      = rx_bit_r;
        rx_shift_n    = rx_shift_r;
        rx_div_n      = rx_div_r;
        rx_done_ok_s  = 1'b0;
        rx_done_err_s = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_n = 16'd0;
                if (rx_fall_s) begin
                    rx_div_n   = divisor_r;
                    rx_state_n = ST_START;
                end else begin
                    rx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_half_end_s) begin
                    rx_cnt_n   = 16'd0;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_sync_r ? ST_IDLE : ST_DATA;
                end else begin
                    rx_state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (rx_bit_end_s) begin
                    rx_cnt_n   = 16'd0;
                    rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
                    rx_bit_n   = rx_bit_r + 3'd1;
                    rx_state_n = (rx_bit_r == 3'd7) ? ST_STOP : ST_DATA;
                end else begin
                    rx_state_n = ST_DATA;
                end
            end
            ST_STOP: begin
                if (rx_bit_end_s) begin
                    rx_cnt_n      = 16'd0;
                    rx_done_ok_s  = rx_sync_r;
                    rx_done_err_s = ~rx_sync_r;
                    rx_state_n    = ST_IDLE;
                end else begin
                    rx_state_n = ST_STOP;
                end
            end
            default: begin
                rx_state_n = ST_IDLE;
            end
        endcase
    end

    // RX synchronizer, state register and holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_div_r   <= DIV_RESET;
            rx_byte_r  <= 8'd0;
            rx_valid_r <= 1'b0;
        end else begin
            rx_meta_r  <= uart_rx;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_bit_r   <= rx_bit_n;
            rx_shift_r <= rx_shift_n;
            rx_div_r   <= rx_div_n;
            if (rx_done_ok_s) begin
                rx_byte_r  <= rx_shift_r;
                rx_valid_r <= 1'b1;
            end else if (rd_rxdata_s) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    // Read mux; a consumed byte reads back as bare 0x80000000.
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr[3:2])
                REG_TXDATA:  rdata = 32'd0;
                REG_RXDATA:  rdata = {~rx_valid_r, 23'd0, (rx_valid_r ? rx_byte_r : 8'd0)};
                REG_STATUS:  rdata = {23'd0, tx_ie_r, 1'b0, rx_frame_err_r, tx_overflow_r,
                                      rx_overrun_r, rx_valid_r, tx_busy_s, tx_empty_s, fifo_full_s};
                REG_DIVISOR: rdata = {16'd0, divisor_r};
                default:     rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

    assign uart_tx = tx_line_r;
    assign irq     = rx_valid_r | (tx_ie_r & tx_empty_s);

endmodule
